// File: rtl/mdu_iterative.sv
// mdu_iterative: multiply/divide unit holding the architectural HI/LO pair.
//   Multiply-class ops (mult, multu, madd, maddu, msub, msubu) keep the unit
//   busy for MULT_LAT cycles. div/divu use a radix-2 restoring divider that
//   produces one quotient bit per cycle, then spends one cycle on sign fixup,
//   for WIDTH+1 busy cycles in total.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   A, B           operands rs / rt (A is also the mthi/mtlo source)
//   start          request a multiply/divide op selected by MultDivOp
//   MultDivOp      1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//                  7 madd, 8 maddu, 9 msub, 10 msubu
//   MDUWrite       request mthi/mtlo (start has priority)
//   req            exception flush; blocks acceptance in the same cycle
//   busy           an operation is in flight
//   hi, lo         committed HI/LO, readable at all times
module mdu_iterative #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             start,
  input  logic [3:0]       MultDivOp,
  input  logic             MDUWrite,
  input  logic             req,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int DIV_LAT = WIDTH + 1;
  localparam int CMAX    = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(CMAX);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [3:0]         op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   quo_q, quo_d, rem_q, rem_d;

  logic               op_valid, op_mul;
  logic               mul_sgn, div_sgn;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod, mul_res;
  logic [WIDTH-1:0]   b_mag, q_fix, r_fix;
  logic [WIDTH:0]     shifted, diff;

  assign op_valid = MultDivOp inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10};
  assign op_mul   = MultDivOp inside {4'd1, 4'd2, 4'd7, 4'd8, 4'd9, 4'd10};

  // Multiply datapath works on the latched operands and the {HI,LO}
  // snapshot taken at acceptance; only the low 2*WIDTH bits are kept.
  assign mul_sgn = op_q inside {4'd1, 4'd7, 4'd9};
  assign a_ext   = mul_sgn ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign b_ext   = mul_sgn ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign prod    = a_ext * b_ext;

  always_comb begin
    mul_res = prod;
    if (op_q inside {4'd7, 4'd8}) mul_res = acc_q + prod;
    if (op_q inside {4'd9, 4'd10}) mul_res = acc_q - prod;
  end

  // Divider runs on magnitudes: quo_q starts as |dividend| and is shifted
  // out MSB-first into the partial remainder while quotient bits shift in.
  assign div_sgn = (op_q == 4'd3);
  assign b_mag   = (div_sgn && b_q[WIDTH-1]) ? -b_q : b_q;
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, b_mag};
  assign q_fix   = (div_sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo_q : quo_q;
  assign r_fix   = (div_sgn && a_q[WIDTH-1]) ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    acc_d   = acc_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !req && op_valid) begin
          a_d    = A;
          b_d    = B;
          op_d   = MultDivOp;
          acc_d  = {hi_q, lo_q};
          busy_d = 1'b1;
          rem_d  = '0;
          if (op_mul) begin
            state_d = S_MUL;
            cnt_d   = CW'(MULT_LAT - 1);
          end else begin
            state_d = S_DIV;
            cnt_d   = CW'(WIDTH - 1);
            quo_d   = (MultDivOp == 4'd3 && A[WIDTH-1]) ? -A : A;
          end
        end else if (!start && MDUWrite && !req) begin
          if (MultDivOp == 4'd5) hi_d = A;
          if (MultDivOp == 4'd6) lo_d = A;
        end
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = mul_res;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DIV: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = S_FIX;
        else cnt_d = cnt_q - CW'(1);
      end
      S_FIX: begin
        // Divide by zero still spends the full period but leaves HI/LO alone.
        if (b_q != '0) begin
          hi_d = r_fix;
          lo_d = q_fix;
        end
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: a transaction-level model of HI/LO
// and busy is compared to the 32-bit DUT on every cycle, directed scenarios
// pin literal results, and a WIDTH=16 / MULT_LAT=1 instance is checked directly.
module tb_mdu_iterative;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        start, mw, rq;
  logic [3:0]  mdop;
  logic        busy;
  logic [31:0] hi, lo;

  logic        rst16;
  logic [15:0] a16, b16;
  logic        start16;
  logic [3:0]  op16;
  logic        busy16;
  logic [15:0] hi16, lo16;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  mdu_iterative #(.WIDTH(32), .MULT_LAT(5)) dut (
    .clk(clk), .reset(rst), .A(a), .B(b), .start(start), .MultDivOp(mdop),
    .MDUWrite(mw), .req(rq), .busy(busy), .hi(hi), .lo(lo)
  );

  mdu_iterative #(.WIDTH(16), .MULT_LAT(1)) dut16 (
    .clk(clk), .reset(rst16), .A(a16), .B(b16), .start(start16), .MultDivOp(op16),
    .MDUWrite(1'b0), .req(1'b0), .busy(busy16), .hi(hi16), .lo(lo16)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] m_hi = '0, m_lo = '0;
  bit          m_busy = 1'b0;
  int          m_left = 0;
  bit          m_keep;
  logic [63:0] m_res, m_acc, m_p, m_q, m_r;
  longint      sa, sb;
  longint unsigned ua, ub;

  always @(posedge clk) begin
    if (rst) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_left = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        if (!m_keep) {m_hi, m_lo} = m_res;
      end
    end else if (start && !rq && (mdop inside {1, 2, 3, 4, 7, 8, 9, 10})) begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
      ua = longint'(a);          ub = longint'(b);
      m_acc  = {m_hi, m_lo};
      m_keep = 1'b0;
      m_busy = 1'b1;
      if (mdop inside {1, 7, 9}) m_p = sa * sb;
      else                       m_p = ua * ub;
      case (mdop)
        1, 2: m_res = m_p;
        7, 8: m_res = m_acc + m_p;
        9, 10: m_res = m_acc - m_p;
        3: begin
          m_keep = (b == 0);
          if (!m_keep) begin
            m_q = sa / sb; m_r = sa % sb;
            m_res = {m_r[31:0], m_q[31:0]};
          end
        end
        default: begin
          m_keep = (b == 0);
          if (!m_keep) m_res = {a % b, a / b};
        end
      endcase
      m_left = (mdop inside {3, 4}) ? 33 : 5;
    end else if (!start && mw && !rq) begin
      if (mdop == 5) m_hi = a;
      if (mdop == 6) m_lo = a;
    end
  end

  // The one compare process: model vs DUT on every cycle after reset.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic st, input logic [3:0] op, input logic w,
                     input logic r, input logic [31:0] av, input logic [31:0] bv);
    start = st; mdop = op; mw = w; rq = r; a = av; b = bv;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    cyc(1'b0, 4'd0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic run_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      idle();
    end
    if (n >= 200) chk("busy_timeout", 64'(n), 64'd0);
  endtask

  task automatic cyc16(input logic st, input logic [3:0] op,
                       input logic [15:0] av, input logic [15:0] bv);
    start16 = st; op16 = op; a16 = av; b16 = bv;
    @(negedge clk); #1;
  endtask

  task automatic run_busy16(output int n);
    n = 0;
    while (busy16 === 1'b1 && n < 100) begin
      n++;
      cyc16(1'b0, 4'd0, '0, '0);
    end
    if (n >= 100) chk("busy16_timeout", 64'(n), 64'd0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; mdop = '0; mw = 1'b0; rq = 1'b0; a = '0; b = '0;
    rst16 = 1'b1; start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    rst = 1'b0;

    // mult -2 * 3
    cyc(1, 1, 0, 0, 32'hFFFF_FFFE, 32'd3);
    run_busy(n);
    chk("mult_lat", 64'(n), 64'd5);
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'hFFFF_FFFA);

    // div -7 / 2
    cyc(1, 3, 0, 0, 32'hFFFF_FFF9, 32'd2);
    run_busy(n);
    chk("div_lat", 64'(n), 64'd33);
    chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(hi), 64'hFFFF_FFFF);

    // divu by zero keeps HI/LO
    cyc(0, 5, 1, 0, 32'h11, 0);
    cyc(0, 6, 1, 0, 32'h22, 0);
    cyc(1, 4, 0, 0, 32'd7, 32'd0);
    run_busy(n);
    chk("divz_lat", 64'(n), 64'd33);
    chk("divz_hi", 64'(hi), 64'h11);
    chk("divz_lo", 64'(lo), 64'h22);

    // mthi/mtlo then maddu, msub
    cyc(0, 5, 1, 0, 32'h1, 0);
    cyc(0, 6, 1, 0, 32'hFFFF_FFFF, 0);
    cyc(1, 8, 0, 0, 32'd1, 32'd1);
    run_busy(n);
    chk("maddu_hi", 64'(hi), 64'h2);
    chk("maddu_lo", 64'(lo), 64'h0);
    cyc(1, 9, 0, 0, 32'd1, 32'd2);
    run_busy(n);
    chk("msub_hi", 64'(hi), 64'h1);
    chk("msub_lo", 64'(lo), 64'hFFFF_FFFE);

    // start blocked by req; mtlo blocked by req
    cyc(1, 1, 0, 1, 32'd3, 32'd4);
    chk("req_block_busy", 64'(busy), 64'd0);
    chk("req_block_lo", 64'(lo), 64'hFFFF_FFFE);
    cyc(0, 6, 1, 1, 32'h1234, 0);
    chk("req_mtlo_lo", 64'(lo), 64'hFFFF_FFFE);

    // MIN / -1
    cyc(1, 3, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_busy(n);
    chk("minneg_lo", 64'(lo), 64'h8000_0000);
    chk("minneg_hi", 64'(hi), 64'h0);

    // req and start while busy are ignored
    cyc(1, 1, 0, 0, 32'd5, 32'd6);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 32'd9, 32'd9);
    cyc(1, 1, 0, 0, 32'd9, 32'd9);
    run_busy(n);
    chk("busy_ignore_lat", 64'(n + 3), 64'd5);
    chk("busy_ignore_lo", 64'(lo), 64'd30);
    chk("busy_ignore_hi", 64'(hi), 64'd0);

    // back-to-back accept in the first idle cycle
    cyc(1, 2, 0, 0, 32'd7, 32'd8);
    chk("b2b_busy", 64'(busy), 64'd1);
    run_busy(n);
    chk("b2b_lat", 64'(n), 64'd5);
    chk("b2b_lo", 64'(lo), 64'd56);

    // reset in busy cycle 10 of a divide
    cyc(1, 3, 0, 0, 32'd100, 32'd7);
    repeat (9) idle();
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_hi", 64'(hi), 64'd0);
    chk("rst_mid_lo", 64'(lo), 64'd0);

    // random traffic against the model
    for (int i = 0; i < 2500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      cyc(($urandom % 4) == 0, 4'($urandom_range(0, 11)), ($urandom % 4) == 0,
          ($urandom % 8) == 0, rnd_val(), rnd_val());
    end
    rst = 1'b0;
    idle();
    run_busy(n);

    // WIDTH=16, MULT_LAT=1 instance
    rst16 = 1'b0;
    cyc16(1, 4, 16'hFFFF, 16'h0010);
    run_busy16(n);
    chk("w16_divu_lat", 64'(n), 64'd17);
    chk("w16_divu_lo", 64'(lo16), 64'h0FFF);
    chk("w16_divu_hi", 64'(hi16), 64'h000F);
    cyc16(1, 1, 16'hFFFE, 16'd3);
    run_busy16(n);
    chk("w16_mult_lat", 64'(n), 64'd1);
    chk("w16_mult_hi", 64'(hi16), 64'hFFFF);
    chk("w16_mult_lo", 64'(lo16), 64'hFFFA);
    cyc16(1, 3, 16'h8000, 16'hFFFF);
    run_busy16(n);
    chk("w16_minneg_lo", 64'(lo16), 64'h8000);
    chk("w16_minneg_hi", 64'(hi16), 64'h0000);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
